// File: rtl/io_ring_ctrl.sv
// io_ring_ctrl - MMIO peripheral controller for the MEM stage of riscv5stage_top.
//
// Owns the LED, switch and program-done registers, detects program completion
// (either a store to the done flag or the fetch PC parking on one address) and
// then sequences the board LEDs: RUN (software-owned LEDs), FLASH (all-on /
// all-off pairs), RING (rotating one-hot pattern, terminal until reset).
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   mem_addr     MEM-stage address (ALU result)
//   mem_wdata    MEM-stage store data
//   mem_we       store strobe
//   mem_re       load strobe
//   mem_rdata    MMIO read data (combinational, zero for non-MMIO or no load)
//   io_hit       mem_addr matches one of the three MMIO addresses
//   if_pc        IF-stage PC, used for halt detection
//   stall        pipeline stall; freezes the halt counter
//   switches     raw board switches (asynchronous)
//   leds         board LEDs
//   led_ring     one-hot ring pattern register
//   program_done sticky completion flag
//   tick_step    one-cycle slow-tick pulse (FLASH and RING only)
//   debug_led    high whenever the sequencer has left RUN
module io_ring_ctrl #(
    parameter logic [31:0] LED_ADDR    = 32'hFFFF_0000,
    parameter logic [31:0] SW_ADDR     = 32'hFFFF_0004,
    parameter logic [31:0] DONE_ADDR   = 32'hFFFF_0008,
    parameter int unsigned TICK_DIV    = 25000000,
    parameter int unsigned FLASH_COUNT = 2,
    parameter int unsigned HALT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        io_hit,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic [3:0]  switches,
    output logic [3:0]  leds,
    output logic [3:0]  led_ring,
    output logic        program_done,
    output logic        tick_step,
    output logic        debug_led
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLASH = 2'd1,
        ST_RING  = 2'd2
    } state_t;

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned FLASH_W = (FLASH_COUNT != 0) ? $clog2(2 * FLASH_COUNT + 1) : 1;
    localparam int unsigned HALT_W  = (HALT_CYCLES != 0) ? $clog2(HALT_CYCLES + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_END  = FLASH_W'(2 * FLASH_COUNT);
    localparam logic [HALT_W-1:0]  HALT_MAX   = HALT_W'(HALT_CYCLES);
    localparam bit                 HALT_EN    = (HALT_CYCLES != 0);

    // One-hot ring rotation helpers; both preserve the one-hot property.
    function automatic logic [3:0] rot_left(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

    function automatic logic [3:0] rot_right(input logic [3:0] r);
        return {r[0], r[3:1]};
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [3:0]           sw_meta_r;
    logic [3:0]           sw_sync_r;
    logic [3:0]           io_leds_r;
    logic [31:0]          pc_q_r;
    logic [HALT_W-1:0]    halt_cnt_r;
    logic                 done_r;
    logic [PRESC_W-1:0]   presc_r;
    logic                 tick_r;
    logic                 phase_r;
    logic [FLASH_W-1:0]   flash_cnt_r;
    logic [FLASH_W-1:0]   flash_inc_s;
    logic [3:0]           ring_r;
    logic                 tick_evt_s;
    logic                 halt_set_s;
    logic                 wr_led_s;
    logic                 wr_done_s;
    logic [31:0]          mem_rdata_s;
    logic [3:0]           leds_s;
    logic                 unused_wdata_s;

    // Only the low nibble of store data is meaningful to any register here.
    assign unused_wdata_s = ^mem_wdata[31:4];

    assign io_hit      = (mem_addr == LED_ADDR) || (mem_addr == SW_ADDR) || (mem_addr == DONE_ADDR);
    assign wr_led_s    = mem_we && (mem_addr == LED_ADDR);
    assign wr_done_s   = mem_we && (mem_addr == DONE_ADDR) && mem_wdata[0];
    // The slow tick fires on the last prescaler count; it is also the edge on
    // which phase, flash count and ring advance, so tick_step lines up with them.
    assign tick_evt_s  = (state_r != ST_RUN) && (presc_r == PRESC_LAST);
    assign halt_set_s  = HALT_EN && (halt_cnt_r == HALT_MAX);
    assign flash_inc_s = flash_cnt_r + FLASH_W'(1);

    assign mem_rdata    = mem_rdata_s;
    assign leds         = leds_s;
    assign led_ring     = ring_r;
    assign program_done = done_r;
    assign tick_step    = tick_r;
    assign debug_led    = (state_r != ST_RUN);

    // MMIO read mux, driven only from registered state.
    always_comb begin
        mem_rdata_s = 32'h0000_0000;
        if (mem_re) begin
            if (mem_addr == LED_ADDR) begin
                mem_rdata_s = {28'h000_0000, io_leds_r};
            end else if (mem_addr == SW_ADDR) begin
                mem_rdata_s = {28'h000_0000, sw_sync_r};
            end else if (mem_addr == DONE_ADDR) begin
                mem_rdata_s = {31'h0000_0000, done_r};
            end else begin
                mem_rdata_s = 32'h0000_0000;
            end
        end else begin
            mem_rdata_s = 32'h0000_0000;
        end
    end

    // LED source select per sequencer state.
    always_comb begin
        leds_s = 4'b0000;
        case (state_r)
            ST_RUN:   leds_s = io_leds_r;
            ST_FLASH: leds_s = phase_r ? 4'b1111 : 4'b0000;
            ST_RING:  leds_s = ring_r;
            default:  leds_s = 4'b0000;
        endcase
    end

    // Sequencer next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (done_r) begin
                    state_nxt_s = (FLASH_COUNT != 0) ? ST_FLASH : ST_RING;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLASH: begin
                if (tick_evt_s && (flash_inc_s == FLASH_END)) begin
                    state_nxt_s = ST_RING;
                end else begin
                    state_nxt_s = ST_FLASH;
                end
            end
            ST_RING:  state_nxt_s = ST_RING;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Two-flop switch synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_r <= 4'b0000;
            sw_sync_r <= 4'b0000;
        end else begin
            sw_meta_r <= switches;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Software LED register; stores are accepted in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_leds_r <= 4'b0000;
        end else if (wr_led_s) begin
            io_leds_r <= mem_wdata[3:0];
        end
    end

    // Halt detector: a PC change clears, a stall freezes, otherwise count up to saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q_r     <= 32'h0000_0000;
            halt_cnt_r <= '0;
        end else begin
            pc_q_r <= if_pc;
            if (if_pc != pc_q_r) begin
                halt_cnt_r <= '0;
            end else if (!stall && (halt_cnt_r != HALT_MAX)) begin
                halt_cnt_r <= halt_cnt_r + HALT_W'(1);
            end
        end
    end

    // Sticky completion flag; simultaneous write and halt collapse into one set.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
        end else if (wr_done_s || halt_set_s) begin
            done_r <= 1'b1;
        end
    end

    // Prescaler, tick pulse, flash phase/count and ring pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r     <= '0;
            tick_r      <= 1'b0;
            phase_r     <= 1'b1;
            flash_cnt_r <= '0;
            ring_r      <= 4'b0001;
        end else begin
            tick_r <= tick_evt_s;
            case (state_r)
                ST_RUN: begin
                    // Held here so FLASH/RING start with a full tick period and phase on.
                    presc_r     <= '0;
                    flash_cnt_r <= '0;
                    phase_r     <= 1'b1;
                end
                ST_FLASH: begin
                    presc_r <= tick_evt_s ? '0 : presc_r + PRESC_W'(1);
                    if (tick_evt_s) begin
                        phase_r     <= ~phase_r;
                        flash_cnt_r <= flash_inc_s;
                        if (flash_inc_s == FLASH_END) begin
                            ring_r <= 4'b0001;
                        end
                    end
                end
                ST_RING: begin
                    presc_r <= tick_evt_s ? '0 : presc_r + PRESC_W'(1);
                    if (tick_evt_s && !sw_sync_r[0]) begin
                        ring_r <= sw_sync_r[3] ? rot_right(ring_r) : rot_left(ring_r);
                    end
                end
                default: begin
                    presc_r <= '0;
                end
            endcase
        end
    end

endmodule
